// File: rtl/ahb_uart_boot_loader.sv
// UART-fed AHB-Lite write master that loads the code memory and holds the CPU in reset until done.
// Optional BOOT_CHECKSUM_EN: a trailing XOR checksum byte is verified before DONE.
module ahb_uart_boot_loader #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned BAUD      = 115200,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned MAX_WORDS = 2048
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        uart_rxd,
  input  logic        HREADY,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  output logic        cpu_hold,
  output logic        boot_done,
  output logic        boot_err
);
  localparam int unsigned DIV = CLK_HZ / BAUD;
  localparam int CNTW = $clog2(DIV) + 1;
  localparam int IDXW = $clog2(MAX_WORDS) + 1;
  localparam logic [CNTW-1:0] HALF_M1 = CNTW'(DIV / 2 - 1);
  localparam logic [CNTW-1:0] FULL_M1 = CNTW'(DIV - 1);
  localparam logic [15:0] MAXW16 = 16'(MAX_WORDS);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_ADDR, S_DPH, S_CHK, S_DONE, S_ERROR
  } state_t;

  state_t r_state, w_next;
  logic [1:0] r_sync;
  logic r_rxPrev, r_rxBusy, r_byteDone, r_frameErr, r_holdValid;
  logic [CNTW-1:0] r_baudCnt;
  logic [3:0] r_bitCnt;
  logic [7:0] r_shift, r_holdByte, r_csum;
  logic [15:0] r_len;
  logic [IDXW-1:0] r_idx;
  logic [1:0] r_byteCnt;
  logic [31:0] r_word, r_hwdata;
  logic w_consume, w_rxErr;
  logic [15:0] w_lenFull;
  logic [IDXW-1:0] w_idxNext;

  // bit counter 0 = start bit (checked at half period), 1..8 = data, 9 = stop
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sync <= 2'b11;
      r_rxPrev <= 1'b1;
      r_rxBusy <= 1'b0;
      r_baudCnt <= '0;
      r_bitCnt <= '0;
      r_shift <= '0;
      r_byteDone <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], uart_rxd};
      r_rxPrev <= r_sync[1];
      r_byteDone <= 1'b0;
      r_frameErr <= 1'b0;
      if (!r_rxBusy) begin
        if (r_rxPrev && !r_sync[1]) begin
          r_rxBusy <= 1'b1;
          r_baudCnt <= '0;
          r_bitCnt <= '0;
        end
      end else if (r_bitCnt == 4'd0 && r_baudCnt == HALF_M1) begin
        r_baudCnt <= '0;
        if (r_sync[1]) r_rxBusy <= 1'b0;
        else r_bitCnt <= 4'd1;
      end else if (r_bitCnt != 4'd0 && r_baudCnt == FULL_M1) begin
        r_baudCnt <= '0;
        if (r_bitCnt == 4'd9) begin
          r_rxBusy <= 1'b0;
          r_byteDone <= r_sync[1];
          r_frameErr <= !r_sync[1];
        end else begin
          r_shift <= {r_sync[1], r_shift[7:1]};
          r_bitCnt <= r_bitCnt + 4'd1;
        end
      end else begin
        r_baudCnt <= r_baudCnt + 1'b1;
      end
    end
  end

  assign w_consume = r_holdValid && (r_state != S_ADDR) && (r_state != S_DPH);
  assign w_rxErr = r_frameErr || (r_byteDone && r_holdValid && !w_consume);
  assign w_lenFull = {r_holdByte, r_len[7:0]};
  assign w_idxNext = r_idx + 1'b1;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_holdValid <= 1'b0;
      r_holdByte <= '0;
    end else if (r_byteDone) begin
      r_holdValid <= 1'b1;
      r_holdByte <= r_shift;
    end else if (w_consume) begin
      r_holdValid <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= S_IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_consume && r_holdByte == 8'hA5) w_next = S_LEN0;
      S_LEN0:  if (w_consume) w_next = S_LEN1;
      S_LEN1: begin
        if (w_consume) begin
          if (w_lenFull == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
            w_next = S_CHK;
`else
            w_next = S_DONE;
`endif
          end else if (w_lenFull > MAXW16) w_next = S_ERROR;
          else w_next = S_DATA;
        end
      end
      S_DATA:  if (w_consume && r_byteCnt == 2'd3) w_next = S_ADDR;
      S_ADDR:  if (HREADY) w_next = S_DPH;
      S_DPH: begin
        if (HREADY) begin
          if (16'(w_idxNext) == r_len) begin
`ifdef BOOT_CHECKSUM_EN
            w_next = S_CHK;
`else
            w_next = S_DONE;
`endif
          end else w_next = S_DATA;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      S_CHK:   if (w_consume) w_next = (r_holdByte == r_csum) ? S_DONE : S_ERROR;
`endif
      S_ERROR: if (w_consume && r_holdByte == 8'hA5) w_next = S_LEN0;
      default: ;
    endcase
    // once loaded, receive errors no longer matter
    if (w_rxErr && r_state != S_DONE) w_next = S_ERROR;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_len <= '0;
      r_idx <= '0;
      r_byteCnt <= '0;
      r_word <= '0;
      r_csum <= '0;
      r_hwdata <= '0;
    end else begin
      if (w_consume) begin
        case (r_state)
          S_LEN0: r_len[7:0] <= r_holdByte;
          S_LEN1: begin
            r_len <= w_lenFull;
            r_byteCnt <= '0;
          end
          S_DATA: begin
            r_word <= {r_holdByte, r_word[31:8]};
            r_byteCnt <= r_byteCnt + 2'd1;
            r_csum <= r_csum ^ r_holdByte;
          end
          default: ;
        endcase
      end
      if (r_state == S_ADDR && w_next == S_DPH) r_hwdata <= r_word;
      if (r_state == S_DPH && HREADY) r_idx <= w_idxNext;
      if (w_next == S_LEN0 && r_state != S_LEN0) begin
        r_idx <= '0;
        r_csum <= '0;
      end
    end
  end

  always_comb begin
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    cpu_hold = 1'b1;
    boot_done = 1'b0;
    boot_err = 1'b0;
    case (r_state)
      S_ADDR: begin
        HTRANS = 2'b10;
        HWRITE = 1'b1;
      end
      S_DONE: begin
        cpu_hold = 1'b0;
        boot_done = 1'b1;
      end
      S_ERROR: boot_err = 1'b1;
      default: ;
    endcase
  end

  assign HADDR = BASE_ADDR + 32'({r_idx, 2'b00});
  assign HSIZE = 3'b010;
  assign HWDATA = r_hwdata;
endmodule

// File: tb/tb_ahb_uart_boot_loader.sv
// Directed bench for ahb_uart_boot_loader: UART byte driver, AHB slave/monitor with optional wait states.
`timescale 1ns/1ps
module tb_ahb_uart_boot_loader;
  localparam int BIT_CYC = 16;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic uart_rxd = 1'b1;
  logic HREADY;
  logic [31:0] HADDR, HWDATA;
  logic [1:0] HTRANS;
  logic HWRITE, cpu_hold, boot_done, boot_err;
  logic [2:0] HSIZE;

  int checks = 0;
  int errors = 0;
  int wrCount = 0;
  int nonseqSeen = 0;
  int stabErr = 0;
  int stallCnt = 0;
  int lastPhase = 0;
  int phase;
  logic inData = 1'b0;
  bit stallMode = 1'b0;
  bit forceLow = 1'b0;
  logic [31:0] snapAddr, snapData;
  logic [1:0] snapTrans;
  logic snapWrite;
  logic [31:0] wrAddr[16];
  logic [31:0] wrData[16];
  logic [7:0] txq[$];
  logic [7:0] csum;
  int wBase, nBase, sBase;

  ahb_uart_boot_loader #(
    .CLK_HZ(1600000), .BAUD(100000), .BASE_ADDR(32'h0), .MAX_WORDS(2048)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .uart_rxd(uart_rxd), .HREADY(HREADY),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .cpu_hold(cpu_hold), .boot_done(boot_done), .boot_err(boot_err)
  );

  always #5 HCLK = ~HCLK;

  // AHB slave model: decides HREADY for the next edge, records completed writes, watches stability
  always @(negedge HCLK) begin
    if (HTRANS == 2'b10) nonseqSeen++;
    if (!HRESETn) begin
      inData = 1'b0;
      lastPhase = 0;
      stallCnt = 0;
      HREADY = 1'b1;
    end else begin
      phase = inData ? 2 : ((HTRANS == 2'b10) ? 1 : 0);
      if (phase != lastPhase) begin
        stallCnt = stallMode ? 3 : 0;
        snapAddr = HADDR;
        snapTrans = HTRANS;
        snapWrite = HWRITE;
        snapData = HWDATA;
      end else if (phase == 1 && (HADDR !== snapAddr || HTRANS !== snapTrans || HWRITE !== snapWrite))
        stabErr++;
      else if (phase == 2 && HWDATA !== snapData)
        stabErr++;
      if (phase == 2 && (HTRANS !== 2'b00 || HWRITE !== 1'b0)) stabErr++;
      lastPhase = phase;
      if (phase == 0) HREADY = 1'b1;
      else if (forceLow || stallCnt > 0) begin
        HREADY = 1'b0;
        if (stallCnt > 0) stallCnt--;
      end else begin
        HREADY = 1'b1;
        if (phase == 1) begin
          if (wrCount < 16) wrAddr[wrCount] = HADDR;
          inData = 1'b1;
        end else begin
          if (wrCount < 16) wrData[wrCount] = HWDATA;
          wrCount++;
          inData = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    @(negedge HCLK);
    uart_rxd = 1'b0;
    waitCycles(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      waitCycles(BIT_CYC);
    end
    uart_rxd = stopBit;
    waitCycles(BIT_CYC);
    uart_rxd = 1'b1;
    waitCycles(4);
  endtask

  task automatic startFrame(input logic [15:0] n);
    csum = 8'h00;
    txq.push_back(8'hA5);
    txq.push_back(n[7:0]);
    txq.push_back(n[15:8]);
  endtask

  task automatic pushWord(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      txq.push_back(w[8*i +: 8]);
      csum ^= w[8*i +: 8];
    end
  endtask

  task automatic pushCsum();
`ifdef BOOT_CHECKSUM_EN
    txq.push_back(csum);
`endif
  endtask

  task automatic sendQueue();
    while (txq.size() > 0) applyStimulus(txq.pop_front(), 1'b1);
    waitCycles(40);
  endtask

  task automatic applyReset();
    @(negedge HCLK);
    HRESETn = 1'b0;
    stallMode = 1'b0;
    forceLow = 1'b0;
    waitCycles(3);
    HRESETn = 1'b1;
    waitCycles(2);
  endtask

  initial begin
    txq.delete();
    // reset values and reset held over a whole word write
    waitCycles(3);
    checkOutput("rstCpuHold", 32'(cpu_hold), 32'd1);
    checkOutput("rstHtrans", 32'(HTRANS), 32'd0);
    checkOutput("rstDone", 32'(boot_done), 32'd0);
    checkOutput("rstErr", 32'(boot_err), 32'd0);
    checkOutput("rstHwrite", 32'(HWRITE), 32'd0);
    checkOutput("rstHsize", 32'(HSIZE), 32'd2);
    checkOutput("rstHaddr", HADDR, 32'h0);
    checkOutput("rstHwdata", HWDATA, 32'h0);
    nBase = nonseqSeen;
    startFrame(16'd1);
    pushWord(32'h44332211);
    sendQueue();
    checkOutput("rstHeldNoNonseq", 32'(nonseqSeen - nBase), 32'd0);
    HRESETn = 1'b1;
    waitCycles(2);

    // two words, no wait states
    wBase = wrCount;
    startFrame(16'd2);
    pushWord(32'h12345678);
    pushWord(32'hDEADBEEF);
    pushCsum();
    sendQueue();
    checkOutput("t2Writes", 32'(wrCount - wBase), 32'd2);
    checkOutput("t2Addr0", wrAddr[wBase], 32'h0);
    checkOutput("t2Data0", wrData[wBase], 32'h12345678);
    checkOutput("t2Addr1", wrAddr[wBase+1], 32'h4);
    checkOutput("t2Data1", wrData[wBase+1], 32'hDEADBEEF);
    checkOutput("t2Done", 32'(boot_done), 32'd1);
    checkOutput("t2CpuHold", 32'(cpu_hold), 32'd0);
    checkOutput("t2Err", 32'(boot_err), 32'd0);

    // same image with three wait states per phase
    applyReset();
    stallMode = 1'b1;
    wBase = wrCount;
    sBase = stabErr;
    startFrame(16'd2);
    pushWord(32'h12345678);
    pushWord(32'hDEADBEEF);
    pushCsum();
    sendQueue();
    checkOutput("t3Writes", 32'(wrCount - wBase), 32'd2);
    checkOutput("t3Stable", 32'(stabErr - sBase), 32'd0);
    checkOutput("t3Data0", wrData[wBase], 32'h12345678);
    checkOutput("t3Addr1", wrAddr[wBase+1], 32'h4);
    checkOutput("t3Data1", wrData[wBase+1], 32'hDEADBEEF);
    checkOutput("t3Done", 32'(boot_done), 32'd1);

    // leading junk then an empty image
    applyReset();
    wBase = wrCount;
    txq.push_back(8'h11);
    txq.push_back(8'h22);
    startFrame(16'd0);
    pushCsum();
    sendQueue();
    checkOutput("t4Writes", 32'(wrCount - wBase), 32'd0);
    checkOutput("t4Done", 32'(boot_done), 32'd1);
    checkOutput("t4CpuHold", 32'(cpu_hold), 32'd0);

    // oversize length, then restart from ERROR
    applyReset();
    startFrame(16'd2049);
    sendQueue();
    checkOutput("t5Err", 32'(boot_err), 32'd1);
    checkOutput("t5CpuHold", 32'(cpu_hold), 32'd1);
    checkOutput("t5NotDone", 32'(boot_done), 32'd0);
    wBase = wrCount;
    startFrame(16'd1);
    pushWord(32'h11223344);
    pushCsum();
    sendQueue();
    checkOutput("t5ErrCleared", 32'(boot_err), 32'd0);
    checkOutput("t5Writes", 32'(wrCount - wBase), 32'd1);
    checkOutput("t5Addr", wrAddr[wBase], 32'h0);
    checkOutput("t5Data", wrData[wBase], 32'h11223344);
    checkOutput("t5Done", 32'(boot_done), 32'd1);

    // framing error
    applyReset();
    applyStimulus(8'h55, 1'b0);
    waitCycles(10);
    checkOutput("t6FrameErr", 32'(boot_err), 32'd1);
    checkOutput("t6FrameHold", 32'(cpu_hold), 32'd1);

`ifdef BOOT_CHECKSUM_EN
    applyReset();
    wBase = wrCount;
    startFrame(16'd1);
    pushWord(32'h04030201);
    txq.push_back(8'hFF);
    sendQueue();
    checkOutput("t6CsumWrites", 32'(wrCount - wBase), 32'd1);
    checkOutput("t6CsumData", wrData[wBase], 32'h04030201);
    checkOutput("t6CsumErr", 32'(boot_err), 32'd1);
    checkOutput("t6CsumNotDone", 32'(boot_done), 32'd0);
`endif

    // reset asserted while an address phase is stalled
    applyReset();
    forceLow = 1'b1;
    wBase = wrCount;
    startFrame(16'd1);
    pushWord(32'hCAFEF00D);
    while (txq.size() > 0) applyStimulus(txq.pop_front(), 1'b1);
    for (int i = 0; i < 200 && HTRANS !== 2'b10; i++) @(negedge HCLK);
    checkOutput("midAddrPhase", 32'(HTRANS), 32'd2);
    HRESETn = 1'b0;
    #1;
    checkOutput("midRstHtrans", 32'(HTRANS), 32'd0);
    checkOutput("midRstHwrite", 32'(HWRITE), 32'd0);
    checkOutput("midRstCpuHold", 32'(cpu_hold), 32'd1);
    waitCycles(3);
    forceLow = 1'b0;
    HRESETn = 1'b1;
    waitCycles(20);
    checkOutput("midNoWrite", 32'(wrCount - wBase), 32'd0);
    checkOutput("midHtransIdle", 32'(HTRANS), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
